jk_bank_sequencer: RTL and testbench

//   Command-driven controller for a bank of WIDTH master-slave JK flip-flops.
//   - Accepts SET/RESET/TOGGLE/LOAD/COUNT commands over a valid/ready handshake.
//   - Drives the bank's J/K inputs one clock at a time and reads Q back.
//   - Sits between a host/testbench sequencer and the JK storage datapath.
//   - The bank holds state (J=K=0) whenever this block is not applying an operation.

---
 rtl/jk_bank_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// Sequences SET/RESET/TOGGLE/LOAD/COUNT commands onto a bank of WIDTH JK flip-flops.
// Latency: accept->done = 3 cycles for SET/RESET/TOGGLE/LOAD, 2n+1 for COUNT n, 1 for NOP/illegal/COUNT 0.
// Backpressure: cmd_ready is high only in IDLE; a held cmd_valid waits until the block returns to IDLE.
//
// Ports:
//   clk                  rising-edge clock
//   clear                asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (transfer = cmd_valid & cmd_ready)
//   cmd_op               0 NOP, 1 SET, 2 RESET, 3 TOGGLE, 4 LOAD, 5 COUNT, 6/7 illegal
//   cmd_mask             bit select for SET/RESET/TOGGLE
//   cmd_data             LOAD value; COUNT step count in cmd_data[CNTW-1:0]
//   abort                synchronous abort, honoured in APPLY and SAMPLE only
//   jk_j/jk_k            registered J/K drive to the bank (zero = hold)
//   jk_q                 Q read-back from the bank
//   busy/done/err        status: not-IDLE, one-cycle completion pulse, sticky error
//
// Build option: define JK_SEQ_VERIFY_EN to check jk_q in SAMPLE against the
// value the operation should have produced; a mismatch sets err and ends the command.

module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_RESET  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNTW-1:0]   steps_q, steps_d;
  logic [WIDTH-1:0]  jk_j_q, jk_j_d;
  logic [WIDTH-1:0]  jk_k_q, jk_k_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  count_t;
  logic [2*WIDTH-1:0] accept_vec;

`ifdef JK_SEQ_VERIFY_EN
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  old_q, old_d;
  logic [WIDTH-1:0]  expect_q_val;
  logic              verify_fail;
`endif

  // J/K vector for one application of an operation, packed as {j, k}.
  // For COUNT the caller supplies the increment vector t.
  function automatic logic [2*WIDTH-1:0] op_vec(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] mask,
    input logic [WIDTH-1:0] data,
    input logic [WIDTH-1:0] t
  );
    logic [2*WIDTH-1:0] v;
    v = '0;
    case (op)
      OP_SET:    v = {mask, {WIDTH{1'b0}}};
      OP_RESET:  v = {{WIDTH{1'b0}}, mask};
      OP_TOGGLE: v = {mask, mask};
      OP_LOAD:   v = {data, ~data};
      OP_COUNT:  v = {t, t};
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Ripple-carry increment as a toggle mask: bit i flips when all lower bits
  // are one. All-ones gives an all-ones mask, so the bank wraps to zero.
  always_comb begin
    logic carry;
    count_t = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      count_t[i] = carry;
      carry      = carry & jk_q[i];
    end
  end

  // J/K is registered, so the vector for the first APPLY is built while
  // still in IDLE, from the incoming command and the bank's current Q.
  assign accept_vec = op_vec(cmd_op, cmd_mask, cmd_data, count_t);

`ifdef JK_SEQ_VERIFY_EN
  // Value the bank should hold after the operation, relative to the Q
  // captured during APPLY (before the closing edge updated the bank).
  always_comb begin
    expect_q_val = old_q;
    case (op_q)
      OP_SET:    expect_q_val = old_q | mask_q;
      OP_RESET:  expect_q_val = old_q & ~mask_q;
      OP_TOGGLE: expect_q_val = old_q ^ mask_q;
      OP_LOAD:   expect_q_val = data_q;
      OP_COUNT:  expect_q_val = old_q + WIDTH'(1);
      default:   expect_q_val = old_q;
    endcase
  end

  assign verify_fail = (jk_q != expect_q_val);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    steps_d = steps_q;
    jk_j_d  = '0;
    jk_k_d  = '0;
    err_d   = err_q;
`ifdef JK_SEQ_VERIFY_EN
    mask_d  = mask_q;
    data_d  = data_q;
    old_d   = old_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          steps_d = cmd_data[CNTW-1:0];
          err_d   = 1'b0;
`ifdef JK_SEQ_VERIFY_EN
          mask_d  = cmd_mask;
          data_d  = cmd_data;
`endif
          case (cmd_op)
            OP_NOP: state_d = ST_DONE;
            OP_SET, OP_RESET, OP_TOGGLE, OP_LOAD: begin
              state_d = ST_APPLY;
              {jk_j_d, jk_k_d} = accept_vec;
            end
            OP_COUNT: begin
              // Zero steps never touches the bank.
              if (cmd_data[CNTW-1:0] == '0) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_APPLY;
                {jk_j_d, jk_k_d} = accept_vec;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end

      ST_APPLY: begin
`ifdef JK_SEQ_VERIFY_EN
        old_d = jk_q;
`endif
        // The bank takes the vector on this cycle's closing edge either way;
        // abort only stops anything further from being applied.
        state_d = abort ? ST_DONE : ST_SAMPLE;
      end

      ST_SAMPLE: begin
        if (op_q == OP_COUNT) begin
          steps_d = steps_q - CNTW'(1);
        end
        if (abort) begin
          state_d = ST_DONE;
`ifdef JK_SEQ_VERIFY_EN
        end else if (verify_fail) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
`endif
        end else if ((op_q == OP_COUNT) && (steps_q != CNTW'(1))) begin
          state_d = ST_APPLY;
          jk_j_d  = count_t;
          jk_k_d  = count_t;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      steps_q <= '0;
      jk_j_q  <= '0;
      jk_k_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      steps_q <= steps_d;
      jk_j_q  <= jk_j_d;
      jk_k_q  <= jk_k_d;
      err_q   <= err_d;
    end
  end

`ifdef JK_SEQ_VERIFY_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mask_q <= '0;
      data_q <= '0;
      old_q  <= '0;
    end else begin
      mask_q <= mask_d;
      data_q <= data_d;
      old_q  <= old_d;
    end
  end
`endif

  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: drives commands into the DUT, models a
// JK bank on its J/K outputs, and checks every cycle against a schedule model.
// The schedule model works on whole commands (arithmetic on Q), not on states.

module tb_jk_bank_sequencer;
  localparam int W = 4;
  localparam bit VERIFY_ON =
`ifdef JK_SEQ_VERIFY_EN
    1'b1;
`else
    1'b0;
`endif

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_mask = '0;
  logic [W-1:0] cmd_data = '0;
  logic         abort = 1'b0;
  logic [W-1:0] jk_j, jk_k, jk_q;
  logic         busy, done, err;

  logic [W-1:0] bank = '0;
  logic [W-1:0] stuck = '0;

  jk_bank_sequencer #(.WIDTH(W), .CNTW(4)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .abort(abort),
    .jk_j(jk_j), .jk_k(jk_k), .jk_q(jk_q), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // JK bank: J=1,K=0 set; J=0,K=1 reset; J=K=1 toggle; J=K=0 hold.
  always @(posedge clk) bank <= (jk_j & ~bank) | (~jk_k & bank);
  // stuck models a Q output line stuck at zero on the read-back path.
  assign jk_q = bank & ~stuck;

  typedef struct packed {
    logic         b;
    logic         r;
    logic         d;
    logic         e;
    logic [W-1:0] j;
    logic [W-1:0] k;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           chk_en = 1'b0;
  logic [W-1:0] m_q = '0;
  logic         m_err = 1'b0;

  function automatic exp_t mk(input logic b, r, d, e, input logic [W-1:0] j, k);
    exp_t x;
    x = {b, r, d, e, j, k};
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Per-cycle compare: the scheduled expectation if a command is in flight,
  // otherwise the idle outputs with the last sticky err.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e, a;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = mk(1'b0, 1'b1, 1'b0, m_err, '0, '0);
      a = mk(busy, cmd_ready, done, err, jk_j, jk_k);
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got busy/rdy/done/err=%b%b%b%b j=%b k=%b, expected %b%b%b%b j=%b k=%b",
                 $time, a.b, a.r, a.d, a.e, a.j, a.k, e.b, e.r, e.d, e.e, e.j, e.k);
      end
    end
  end

  // Issue one command, build its cycle schedule from the operation rules,
  // optionally abort in cycle abort_at (1-based after accept), then wait for it to drain.
  task automatic run(input logic [2:0] op, input logic [W-1:0] mask, input logic [W-1:0] data,
                     input int abort_at, output int lat);
    logic [W-1:0] q, nq, vj, vk;
    int  steps, cyc, guard;
    logic e;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    q = m_q; e = 1'b0; cyc = 0;
    if (op == 3'd0 || op > 3'd5 || (op == 3'd5 && data == '0)) begin
      e = (op > 3'd5);
    end else begin
      steps = (op == 3'd5) ? int'(data) : 1;
      for (int s = 0; s < steps; s++) begin
        vj = '0; vk = '0; nq = q;
        case (op)
          3'd1: begin vj = mask;  vk = '0;    nq = q | mask;  end
          3'd2: begin vj = '0;    vk = mask;  nq = q & ~mask; end
          3'd3: begin vj = mask;  vk = mask;  nq = q ^ mask;  end
          3'd4: begin vj = data;  vk = ~data; nq = data;      end
          default: begin nq = q + W'(1); vj = q ^ nq; vk = vj; end
        endcase
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, vj, vk)); cyc++;
        q = nq;
        if (abort_at == cyc) break;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0)); cyc++;
        if (abort_at == cyc) break;
        if (VERIFY_ON && ((q & ~stuck) != nq)) begin e = 1'b1; break; end
      end
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, e, '0, '0)); cyc++;
    m_q = q; m_err = e; lat = cyc;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk); guard++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_rdy", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_jk", {jk_j, jk_k}, 0);
    clear = 1'b1;

    // Asynchronous reset in the middle of APPLY
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_mask = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("apply_j", jk_j, 4'hF);
    clear = 1'b0;
    #1;
    check("midrst_jk", {jk_j, jk_k}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdy", cmd_ready, 1);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    check("midrst_bank", jk_q, 4'h0);
    chk_en = 1'b1;

    // Writes
    run(3'd4, 4'b0000, 4'b1010, 0, lat);
    check("lat_load", lat, 3);
    check("q_load", jk_q, 4'b1010);
    run(3'd1, 4'b0101, 4'b0000, 0, lat);
    check("q_set", jk_q, 4'b1111);

    // Masked ops
    run(3'd3, 4'b1001, 4'b0000, 0, lat);
    check("q_toggle", jk_q, 4'b0110);
    run(3'd2, 4'b0110, 4'b0000, 0, lat);
    check("q_reset", jk_q, 4'b0000);

    // Counting, including wrap through all-ones
    run(3'd4, 4'b0000, 4'b1110, 0, lat);
    run(3'd5, 4'b0000, 4'd3, 0, lat);
    check("lat_count3", lat, 7);
    check("q_count3", jk_q, 4'b0001);
    run(3'd5, 4'b0000, 4'd0, 0, lat);
    check("lat_count0", lat, 1);
    check("q_count0", jk_q, 4'b0001);

    // Illegal op, cleared by the next accepted NOP
    run(3'd7, 4'b1111, 4'b1111, 0, lat);
    check("err_illegal", err, 1);
    check("q_illegal", jk_q, 4'b0001);
    run(3'd0, 4'b0000, 4'b0000, 0, lat);
    check("err_nop_clear", err, 0);
    check("lat_nop", lat, 1);

    // Abort in the 2nd SAMPLE of COUNT 5, then in the 1st APPLY of COUNT 2
    run(3'd5, 4'b0000, 4'd5, 4, lat);
    check("q_abort_sample", jk_q, 4'b0011);
    run(3'd5, 4'b0000, 4'd2, 1, lat);
    check("q_abort_apply", jk_q, 4'b0100);

    // Abort while idle has no effect
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (2) @(posedge clk);

    // Read-back fault: bit0 stuck at zero during LOAD 0001
    stuck = 4'b0001;
    run(3'd4, 4'b0000, 4'b0001, 0, lat);
    check("err_verify", err, VERIFY_ON ? 1 : 0);
    stuck = 4'b0000;
    #1;
    check("q_after_stuck", jk_q, 4'b0001);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
